// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging four beat sources into one FIFO write port, bursts capped at MAX_BURST.
// Latency: an accepted beat is written to the FIFO one cycle after acceptance; one idle cycle between grants.
// Backpressure: f_prog_full or f_full deasserts s_ready for the granted source without releasing the grant.
module fifo_wr_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   s_valid,
  input  logic [511:0] s_data,
  input  logic [3:0]   s_last,
  output logic [3:0]   s_ready,
  output logic [127:0] f_din,
  output logic [15:0]  f_dinp,
  output logic         f_wr_en,
  input  logic         f_full,
  input  logic         f_prog_full,
  output logic [3:0]   grant,
  output logic         ovf_err
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  state_t       state;
  logic [1:0]   gidx;
  logic [1:0]   rr_ptr;
  logic [7:0]   beat_cnt;

  logic         fifo_ok;
  logic         accept;
  logic         beat_last;
  logic         burst_end;
  logic [127:0] beat_data;
  logic         pick_vld;
  logic [1:0]   pick_idx;
  logic [1:0]   cand;

  // Only the owner is ever offered ready; the FIFO flags gate it combinationally.
  assign fifo_ok   = (state == XFER) && !f_prog_full && !f_full;
  assign s_ready   = grant & {4{fifo_ok}};
  assign accept    = |(s_valid & s_ready);
  assign beat_data = s_data[{gidx, 7'd0} +: 128];
  assign beat_last = s_last[gidx];
  assign burst_end = beat_last || ((beat_cnt + 8'd1) == MAX_CNT);

  // Round-robin pick: first valid source at or above rr_ptr, wrapping mod 4.
  // Scanning from the far end means the nearest requester is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    cand     = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (s_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Arbitration FSM with registered FIFO write port and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'd0;
      gidx     <= 2'd0;
      rr_ptr   <= 2'd0;
      beat_cnt <= 8'd0;
      f_wr_en  <= 1'b0;
      f_din    <= 128'd0;
      f_dinp   <= 16'd0;
      ovf_err  <= 1'b0;
    end else begin
      f_wr_en <= accept;
      if (accept) begin
        f_din  <= beat_data;
        f_dinp <= {13'd0, beat_last, gidx};
      end
      if (f_wr_en && f_full) begin
        ovf_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= XFER;
            grant    <= 4'b0001 << pick_idx;
            gidx     <= pick_idx;
            beat_cnt <= 8'd0;
          end
        end
        XFER: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (burst_end) begin
              state  <= IDLE;
              grant  <= 4'd0;
              rr_ptr <= gidx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a cycle reference model
// and a per-source in-order beat scoreboard.
module tb_fifo_wr_arbiter;

  localparam int MB = 16;

  logic         clk;
  logic         rst_n;
  logic [3:0]   s_valid;
  logic [511:0] s_data;
  logic [3:0]   s_last;
  logic [3:0]   s_ready;
  logic [127:0] f_din;
  logic [15:0]  f_dinp;
  logic         f_wr_en;
  logic         f_full;
  logic         f_prog_full;
  logic [3:0]   grant;
  logic         ovf_err;

  fifo_wr_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .f_din(f_din), .f_dinp(f_dinp), .f_wr_en(f_wr_en),
    .f_full(f_full), .f_prog_full(f_prog_full), .grant(grant), .ovf_err(ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Per-source beat storage: head = next beat offered, wr_idx = next beat expected at the FIFO.
  logic [127:0] bt_dat  [4][256];
  bit           bt_last [4][256];
  int head [4];
  int tail [4];
  int wr_idx [4];
  int gap_left [4];

  // Reference model: current owner (-1 = none), pointer, beats this grant, pending write.
  int m_owner, m_ptr, m_cnt, m_tag;
  bit m_wr, m_ovf;
  int glog [$];

  int gap_pct, pf_pct, pf_lo, pf_hi, pcyc;
  bit ovf_mode;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void add_pkt(int s, int len);
    logic [127:0] d;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[127:112] = 16'(s * 256 + tail[s]);
      bt_dat[s][tail[s]]  = d;
      bt_last[s][tail[s]] = (b == len - 1);
      tail[s]++;
    end
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0; tail[i] = 0; wr_idx[i] = 0; gap_left[i] = 0;
    end
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_tag = 0; m_wr = 1'b0; m_ovf = 1'b0;
    glog.delete();
  endfunction

  function automatic bit all_done();
    bit d;
    d = (m_owner < 0) && !m_wr;
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) d = 1'b0;
    return d;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [3:0] gexp, rexp;
    bit acc, v;
    int pick, s;
    gexp = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    chk("grant", 128'(grant), 128'(gexp));
    chk("f_wr_en", 128'(f_wr_en), 128'(m_wr));
    chk("ovf_err", 128'(ovf_err), 128'(m_ovf));
    if (m_wr) begin
      chk("f_din", f_din, bt_dat[m_tag][wr_idx[m_tag]]);
      chk("f_dinp", 128'(f_dinp), 128'({13'd0, bt_last[m_tag][wr_idx[m_tag]], 2'(m_tag)}));
      wr_idx[m_tag]++;
    end
    for (int i = 0; i < 4; i++) begin
      v = (head[i] < tail[i]) && (gap_left[i] == 0) && ($urandom_range(0, 99) >= gap_pct);
      if (gap_left[i] > 0) gap_left[i]--;
      s_valid[i] = v;
      s_last[i]  = v ? bt_last[i][head[i]] : 1'($urandom);
      s_data[128*i +: 128] = v ? bt_dat[i][head[i]] : {$urandom, $urandom, $urandom, $urandom};
    end
    f_prog_full = (pcyc >= pf_lo && pcyc <= pf_hi) || ($urandom_range(0, 99) < pf_pct);
    f_full = ovf_mode && ((m_wr && !m_ovf) || ($urandom_range(0, 9) == 0));
    #1;
    rexp = (m_owner >= 0 && !f_prog_full && !f_full) ? 4'(1 << m_owner) : 4'd0;
    chk("s_ready", 128'(s_ready), 128'(rexp));
    m_ovf = m_ovf || (m_wr && f_full);
    acc = 1'b0;
    if (m_owner >= 0) acc = !f_prog_full && !f_full && s_valid[m_owner];
    m_wr = acc;
    if (m_owner < 0) begin
      pick = -1;
      for (int k = 0; k < 4; k++)
        if (pick < 0 && s_valid[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      if (pick >= 0) begin
        m_owner = pick; m_cnt = 0; glog.push_back(pick);
      end
    end else if (acc) begin
      s = m_owner;
      m_tag = s;
      head[s]++;
      m_cnt++;
      if (s_last[s] || m_cnt == MB) begin
        m_ptr = (s + 1) % 4;
        m_owner = -1;
      end
    end
    pcyc++;
    @(negedge clk);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (!all_done() && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 128'(n < 3000), 128'(1));
    for (int i = 0; i < 4; i++) chk({tag, "_count"}, 128'(wr_idx[i]), 128'(tail[i]));
  endtask

  // Entered at a falling edge; outputs must clear without any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_f_wr_en", 128'(f_wr_en), 128'(0));
    chk("rst_f_din", f_din, 128'(0));
    chk("rst_f_dinp", 128'(f_dinp), 128'(0));
    chk("rst_ovf_err", 128'(ovf_err), 128'(0));
    s_valid = 4'd0; f_full = 1'b0; f_prog_full = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_grant", 128'(grant), 128'(0));
    chk("rel_f_wr_en", 128'(f_wr_en), 128'(0));
    @(negedge clk);
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};
  bit gd;
  bit hit;

  initial begin
    rst_n = 1'b1; s_valid = 4'd0; s_last = 4'd0; s_data = '0;
    f_full = 1'b0; f_prog_full = 1'b0;
    gap_pct = 0; pf_pct = 0; pf_lo = -1; pf_hi = -1; pcyc = 0; ovf_mode = 1'b0;
    clear_all();
    @(negedge clk);
    do_reset();

    // All four sources, two 3-beat packets each: strict rotation from pointer 0.
    for (int s = 0; s < 4; s++) begin add_pkt(s, 3); add_pkt(s, 3); end
    drain("rr");
    chk("rr_ngrant", 128'(glog.size()), 128'(8));
    for (int k = 0; k < 5; k++) chk("rr_order", 128'(glog[k]), 128'(ord[k]));

    // One 40-beat packet from source 2 is cut into 16 + 16 + 8.
    glog.delete();
    add_pkt(2, 40);
    drain("burst");
    chk("burst_ngrant", 128'(glog.size()), 128'(3));
    for (int k = 0; k < 3; k++) chk("burst_owner", 128'(glog[k]), 128'(2));

    // Source 1 streaming with prog_full asserted for cycles 5..9.
    glog.delete();
    pcyc = 0; pf_lo = 5; pf_hi = 9;
    add_pkt(1, 30);
    drain("pfull");
    pf_lo = -1; pf_hi = -1;
    chk("pfull_ngrant", 128'(glog.size()), 128'(2));

    // Source 0 stalls four cycles mid-packet while source 3 waits.
    glog.delete();
    add_pkt(0, 5);
    step();
    add_pkt(3, 2);
    gd = 1'b0;
    for (int n = 0; n < 50 && !gd; n++) begin
      if (head[0] == 2) begin gap_left[0] = 4; gd = 1'b1; end
      step();
    end
    drain("gap");
    chk("gap_ngrant", 128'(glog.size()), 128'(2));
    chk("gap_first", 128'(glog[0]), 128'(0));
    chk("gap_second", 128'(glog[1]), 128'(3));

    // Random traffic: valid gaps, prog_full noise, packets around MAX_BURST.
    gap_pct = 20; pf_pct = 15;
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 6; p++) add_pkt(s, int'($urandom_range(1, 20)));
    drain("rand");
    gap_pct = 0; pf_pct = 0;

    // FIFO full while a write is presented: sticky error.
    ovf_mode = 1'b1;
    for (int s = 0; s < 4; s++) add_pkt(s, 4);
    drain("ovf");
    ovf_mode = 1'b0;
    chk("ovf_set", 128'(ovf_err), 128'(1));
    repeat (3) step();
    chk("ovf_sticky", 128'(ovf_err), 128'(1));

    // Reset while source 2 is offering beat 2 of 5; pointer was 3 beforehand.
    add_pkt(2, 1);
    add_pkt(2, 5);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      step();
      hit = (m_owner == 2) && (m_cnt == 1) && m_wr && (tail[2] - head[2] == 4);
    end
    chk("rst_reached", 128'(hit), 128'(1));
    do_reset();
    add_pkt(1, 2);
    add_pkt(3, 2);
    drain("post_rst");
    chk("restart_first", 128'(glog[0]), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
